// File: rtl/mkio_word_tx.sv
// mkio_word_tx: Manchester-II MKIO word transmitter (3-bit-time sync, 16 data bits MSB first, odd parity).
// Optional feature macro MKIO_TX_ERR_INJECT_EN adds tx_par_err, which inverts the transmitted parity.
module mkio_word_tx #(
    parameter int HALF_BIT_CLKS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_valid,
    input  logic        tx_sync,
    input  logic [15:0] tx_data,
`ifdef MKIO_TX_ERR_INJECT_EN
    input  logic        tx_par_err,
`endif
    output logic        tx_ready,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        DO1,
    output logic        DO0,
    output logic        TX_INHIBIT
);
    localparam int CNT_W = $clog2(HALF_BIT_CLKS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_BIT_CLKS - 1);
    localparam logic [5:0] IDX_MAX = 6'd39;

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] half_cnt, half_cnt_nxt;
    logic [5:0]       half_idx, half_idx_nxt;
    logic [39:0]      shreg, shreg_nxt;
    logic [39:0]      new_word;
    logic             ready_q;
    logic             accept;
    logic             last_nxt;
    logic             par_err;

`ifdef MKIO_TX_ERR_INJECT_EN
    assign par_err = tx_par_err;
`else
    assign par_err = 1'b0;
`endif

    // Whole word as half-bits, MSB (bit 39) goes on the line first.
    function automatic logic [39:0] build_word(input logic sync, input logic [15:0] data,
                                               input logic par);
        logic [39:0] w;
        w[39:34] = sync ? 6'b111000 : 6'b000111;
        for (int i = 0; i < 16; i++) begin
            w[33 - 2*i] = data[15 - i];
            w[32 - 2*i] = ~data[15 - i];
        end
        w[1] = par;
        w[0] = ~par;
        return w;
    endfunction

    assign tx_ready = ready_q & ~reset;
    assign accept   = tx_valid & tx_ready;
    assign new_word = build_word(tx_sync, tx_data, (~^tx_data) ^ par_err);

    always_comb begin
        state_nxt    = state;
        half_cnt_nxt = half_cnt;
        half_idx_nxt = half_idx;
        shreg_nxt    = shreg;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt    = SEND;
                    shreg_nxt    = new_word;
                    half_cnt_nxt = '0;
                    half_idx_nxt = '0;
                end
            end
            SEND: begin
                if (half_cnt == CNT_MAX) begin
                    half_cnt_nxt = '0;
                    if (half_idx == IDX_MAX) begin
                        // accept is only possible here, giving gap-free back-to-back words
                        half_idx_nxt = '0;
                        if (accept) begin
                            shreg_nxt = new_word;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        half_idx_nxt = half_idx + 6'd1;
                        shreg_nxt    = {shreg[38:0], 1'b0};
                    end
                end else begin
                    half_cnt_nxt = half_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign last_nxt = (state_nxt == SEND) && (half_idx_nxt == IDX_MAX) && (half_cnt_nxt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            half_cnt   <= '0;
            half_idx   <= '0;
            shreg      <= '0;
            ready_q    <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            DO1        <= 1'b0;
            DO0        <= 1'b0;
            TX_INHIBIT <= 1'b1;
        end else begin
            state      <= state_nxt;
            half_cnt   <= half_cnt_nxt;
            half_idx   <= half_idx_nxt;
            shreg      <= shreg_nxt;
            ready_q    <= (state_nxt == IDLE) || last_nxt;
            tx_busy    <= (state_nxt == SEND);
            tx_done    <= last_nxt;
            DO1        <= (state_nxt == SEND) & shreg_nxt[39];
            DO0        <= (state_nxt == SEND) & ~shreg_nxt[39];
            TX_INHIBIT <= (state_nxt != SEND);
        end
    end

endmodule

// File: tb/tb_mkio_word_tx.sv
// tb_mkio_word_tx: randomized scoreboard bench for mkio_word_tx against a half-bit level reference model.
module tb_mkio_word_tx;
    localparam int H         = 16;
    localparam int WORD_CLKS = 40 * H;
`ifdef MKIO_TX_ERR_INJECT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        tx_valid   = 1'b0;
    logic        tx_sync    = 1'b0;
    logic [15:0] tx_data    = 16'h0000;
    logic        par_err_drv = 1'b0;
    logic        tx_ready, tx_busy, tx_done, DO1, DO0, TX_INHIBIT;

    mkio_word_tx #(.HALF_BIT_CLKS(H)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_valid   (tx_valid),
        .tx_sync    (tx_sync),
        .tx_data    (tx_data),
`ifdef MKIO_TX_ERR_INJECT_EN
        .tx_par_err (par_err_drv),
`endif
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .DO1        (DO1),
        .DO0        (DO0),
        .TX_INHIBIT (TX_INHIBIT)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sync;
        logic [15:0] data;
        logic        err;
    } word_t;

    word_t exp_q[$];
    logic  samples[$];
    word_t m_cur = '0;
    int    m_pos = -1;
    int    acc_count = 0;
    int    words_expected = 0;
    int    done_seen = 0;
    bit    mon_en = 1'b0;
    int    checks = 0;
    int    failures = 0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Half-bit k of a word straight from the word-format rules; parity makes the ones count odd.
    function automatic logic exp_half(input word_t w, input int k);
        logic p;
        p = (($countones(w.data) % 2) == 0) ^ w.err;
        if (k < 6)   return w.sync ? (k < 3) : (k >= 3);
        if (k >= 38) return (k == 38) ? p : ~p;
        return (((k - 6) % 2) == 0) ? w.data[15 - (k - 6) / 2] : ~w.data[15 - (k - 6) / 2];
    endfunction

    // Reference timeline: position within the word on the line, or -1 when idle.
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_pos = -1;
        end else begin
            if (m_pos == WORD_CLKS - 1) words_expected++;
            if (tx_valid && (m_pos < 0 || m_pos == WORD_CLKS - 1)) begin
                m_cur.sync = tx_sync;
                m_cur.data = tx_data;
                m_cur.err  = par_err_drv & ERR_EN;
                exp_q.push_back(m_cur);
                m_pos = 0;
                acc_count++;
            end else if (m_pos >= 0) begin
                m_pos++;
                if (m_pos == WORD_CLKS) m_pos = -1;
            end
        end
    end

    task automatic check_word(input word_t w);
        logic [39:0] act_vec, exp_vec;
        int          uneven;
        check_output("word_length", samples.size(), WORD_CLKS);
        if (samples.size() == WORD_CLKS) begin
            uneven = 0;
            for (int k = 0; k < 40; k++) begin
                act_vec[39 - k] = samples[k * H];
                exp_vec[39 - k] = exp_half(w, k);
                for (int j = 1; j < H; j++)
                    if (samples[k * H + j] !== samples[k * H]) uneven++;
            end
            check_output("word_halfbits", act_vec, exp_vec);
            check_output("halfbit_width", uneven, 0);
        end
    endtask

    // Monitor: per-cycle control/line checks plus scoreboard pop on every tx_done.
    always @(negedge clk) begin
        if (mon_en) begin
            logic e;
            check_output("ctrl {inhibit,busy,done,ready}",
                         {TX_INHIBIT, tx_busy, tx_done, tx_ready},
                         {m_pos < 0, m_pos >= 0, m_pos == WORD_CLKS - 1,
                          (m_pos < 0 || m_pos == WORD_CLKS - 1) && !reset});
            if (m_pos >= 0) begin
                e = exp_half(m_cur, m_pos / H);
                check_output("line {DO1,DO0}", {DO1, DO0}, {e, ~e});
            end else begin
                check_output("line_idle {DO1,DO0}", {DO1, DO0}, 2'b00);
            end
            if (tx_busy) samples.push_back(DO1);
            else samples.delete();
            if (tx_done) begin
                done_seen++;
                check_output("scoreboard_nonempty", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) check_word(exp_q.pop_front());
                samples.delete();
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic [15:0] d, input logic e, input bit keep);
        int start;
        int budget;
        start  = acc_count;
        budget = 0;
        tx_valid    = 1'b1;
        tx_sync     = s;
        tx_data     = d;
        par_err_drv = e;
        while (acc_count == start && budget < 2 * WORD_CLKS) begin
            step(1);
            budget++;
        end
        check_output("accept", acc_count - start, 1);
        if (!keep) begin
            tx_valid = 1'b0;
            tx_data  = 16'($urandom);
            tx_sync  = 1'($urandom);
        end
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while (m_pos >= 0 && budget < 2 * WORD_CLKS) begin
            step(1);
            budget++;
        end
        check_output("idle_reached", m_pos < 0, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        step(2);
        mon_en = 1'b1;
        // Request already pending while reset is still high; must wait for reset release.
        tx_valid = 1'b1;
        tx_sync  = 1'b1;
        tx_data  = 16'h0847;
        step(1);
        reset = 1'b0;
        apply_stimulus(1'b1, 16'h0847, 1'b0, 1'b0);
        wait_idle();
        step(3);

        apply_stimulus(1'b0, 16'hFFFF, 1'b0, 1'b0);
        wait_idle();
        apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        wait_idle();
        step(2);

        apply_stimulus(1'b1, 16'($urandom), 1'b0, 1'b1);
        apply_stimulus(1'b0, 16'h1234, 1'b0, 1'b1);
        apply_stimulus(1'b0, 16'hABCD, 1'b0, 1'b0);
        wait_idle();
        step(4);

        apply_stimulus(1'b1, 16'($urandom), 1'b0, 1'b0);
        step(20 * H + 3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(5);
        apply_stimulus(1'b0, 16'($urandom), 1'b0, 1'b0);
        wait_idle();

        if (ERR_EN) begin
            apply_stimulus(1'b1, 16'h0847, 1'b1, 1'b0);
            wait_idle();
            apply_stimulus(1'b1, 16'h0847, 1'b0, 1'b0);
            wait_idle();
        end

        for (int i = 0; i < 15; i++) begin
            apply_stimulus(1'($urandom), 16'($urandom), 1'($urandom) & ERR_EN,
                           ($urandom_range(0, 2) != 0));
            if (!tx_valid) begin
                wait_idle();
                step($urandom_range(0, 5));
            end
        end
        tx_valid = 1'b0;
        wait_idle();
        step(5);

        check_output("done_count", done_seen, words_expected);
        check_output("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
